// File: rtl/puzzle_seq_pkg.sv
// Shared state encoding and index width for the puzzle run sequencer.
package puzzle_seq_pkg;

  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PULSE = 3'd2,
    WAIT  = 3'd3,
    CAPT  = 3'd4,
    GAP   = 3'd5,
    FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/puzzle_run_sequencer_sync_2ff.sv
// Width-parameterised two-flop synchroniser, asynchronously cleared to 0.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      q_o    <= '0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/puzzle_run_sequencer.sv
// Runs NUM_PUZ puzzle boards one at a time and collects their final colour bits.
// Optional per-run watchdog and timed_out port: define RUN_TIMEOUT_EN.
module puzzle_run_sequencer
  import puzzle_seq_pkg::*;
#(
  parameter int unsigned NUM_PUZ     = 4,
  parameter int unsigned START_CYC   = 1,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  output logic [NUM_PUZ-1:0] start,
  input  logic [NUM_PUZ-1:0] stopped,
  input  logic [NUM_PUZ-1:0] colour,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   cur_idx,
  output logic [NUM_PUZ-1:0] result,
  output logic [NUM_PUZ-1:0] valid
`ifdef RUN_TIMEOUT_EN
  ,
  output logic [NUM_PUZ-1:0] timed_out
`endif
);

  localparam int unsigned CNT_LIM  = (START_CYC > GAP_CYC) ? START_CYC : GAP_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_LIM) + 1;
  localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;

  if (NUM_PUZ < 1 || NUM_PUZ > 16 || START_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("puzzle_run_sequencer: parameter out of range");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_PUZ-1:0]   start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_PUZ-1:0]   result_q, result_d;
  logic [NUM_PUZ-1:0]   valid_q, valid_d;
  logic                 col_q, col_d;
  logic [NUM_PUZ-1:0]   stp_s;
  logic [NUM_PUZ-1:0]   sel;
  logic                 stp_cur;
  logic                 last;

`ifdef RUN_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [NUM_PUZ-1:0]   tmo_q, tmo_d;
  assign timed_out = tmo_q;
`endif

  sync_2ff #(.W(NUM_PUZ)) u_stp_sync (
    .clk (clk),
    .rst (rst),
    .d_i (stopped),
    .q_o (stp_s)
  );

  assign sel     = NUM_PUZ'(1) << idx_q;
  assign stp_cur = |(stp_s & sel);
  assign last    = (idx_q == IDX_W'(NUM_PUZ - 1));

  assign start   = start_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_idx = idx_q;
  assign result  = result_q;
  assign valid   = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      start_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= '0;
      col_q    <= 1'b0;
`ifdef RUN_TIMEOUT_EN
      wd_q     <= '0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      col_q    <= col_d;
`ifdef RUN_TIMEOUT_EN
      wd_q     <= wd_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  // Next state; registered outputs are derived from the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    result_d = result_q;
    valid_d  = valid_q;
    col_d    = col_q;
`ifdef RUN_TIMEOUT_EN
    wd_d     = wd_q;
    tmo_d    = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (go) begin
          result_d = '0;
          valid_d  = '0;
          idx_d    = '0;
`ifdef RUN_TIMEOUT_EN
          tmo_d    = '0;
`endif
          state_d  = ARM;
        end
      end
      ARM: begin
        // A stopped flag left over from an earlier run must clear first.
        if (!stp_cur) begin
          cnt_d   = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(START_CYC - 1)) begin
          state_d = WAIT;
`ifdef RUN_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (stp_cur) begin
          col_d   = |(colour & sel);
          state_d = CAPT;
        end
`ifdef RUN_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          col_d   = 1'b0;
          tmo_d   = tmo_q | sel;
          state_d = CAPT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      CAPT: begin
        result_d = (result_q & ~sel) | (col_q ? sel : '0);
        valid_d  = valid_q | sel;
        if (last) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = (GAP_CYC == 0) ? ARM : GAP;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_LAST)) begin
          state_d = ARM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    start_d = (state_d == PULSE) ? (NUM_PUZ'(1) << idx_d) : '0;
    busy_d  = state_d inside {ARM, PULSE, WAIT, CAPT, GAP};
    done_d  = (state_d == FIN);
  end

endmodule

// File: tb/tb_puzzle_run_sequencer.sv
// Directed bench: four puzzle stubs on the default DUT, plus a START_CYC=3/GAP_CYC=0 instance.
`timescale 1ns/1ps
module tb_puzzle_run_sequencer;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst, go, go2;
  logic [N-1:0] start, stopped, colour, result, valid;
  logic         busy, done;
  logic [3:0]   cur_idx;
  logic [1:0]   start2, stopped2, colour2, result2, valid2;
  logic         busy2, done2;
  logic [3:0]   cur_idx2;
`ifdef RUN_TIMEOUT_EN
  logic [N-1:0] timed_out;
  logic [1:0]   timed_out2;
`endif

  always #5 clk = ~clk;

  puzzle_run_sequencer #(.NUM_PUZ(N), .START_CYC(1), .GAP_CYC(2), .TIMEOUT_CYC(100)) u_dut (
    .clk(clk), .rst(rst), .go(go), .start(start), .stopped(stopped), .colour(colour),
    .busy(busy), .done(done), .cur_idx(cur_idx), .result(result), .valid(valid)
`ifdef RUN_TIMEOUT_EN
    , .timed_out(timed_out)
`endif
  );

  puzzle_run_sequencer #(.NUM_PUZ(2), .START_CYC(3), .GAP_CYC(0)) u_dut2 (
    .clk(clk), .rst(rst), .go(go2), .start(start2), .stopped(stopped2), .colour(colour2),
    .busy(busy2), .done(done2), .cur_idx(cur_idx2), .result(result2), .valid(valid2)
`ifdef RUN_TIMEOUT_EN
    , .timed_out(timed_out2)
`endif
  );

  // Puzzle stubs: a start pulse arms a countdown; on expiry stopped rises with the colour.
  int unsigned  dly [N] = '{20, 35, 50, 10};
  logic [N-1:0] col_cfg = 4'b0110;
  logic [N-1:0] stub_stop, stp_force;
  logic         stub_clr;
  int unsigned  stub_cnt [N];

  assign stopped = stub_stop | stp_force;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (stub_clr) begin
        stub_stop[i] <= 1'b0;
        colour[i]    <= 1'b0;
        stub_cnt[i]  <= 0;
      end else if (start[i]) begin
        stub_stop[i] <= 1'b0;
        stub_cnt[i]  <= dly[i];
      end else if (stub_cnt[i] == 1) begin
        stub_stop[i] <= 1'b1;
        colour[i]    <= col_cfg[i];
        stub_cnt[i]  <= 0;
      end else if (stub_cnt[i] > 1) begin
        stub_cnt[i]  <= stub_cnt[i] - 1;
      end
    end
  end

  int           rise_idx [$];
  int           widths [$];
  int           cur_w;
  int           done_cnt  = 0;
  int           multi_hot = 0;
  logic [N-1:0] start_prev = '0;

  always @(negedge clk) begin
    if ($countones(start) > 1) multi_hot++;
    if (start != 0 && start_prev == 0) begin
      rise_idx.push_back($clog2(start));
      cur_w = 1;
    end else if (start != 0) begin
      cur_w++;
    end else if (start_prev != 0) begin
      widths.push_back(cur_w);
    end
    if (done) done_cnt++;
    start_prev = start;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_stubs();
    @(negedge clk) stub_clr = 1'b1;
    @(negedge clk) stub_clr = 1'b0;
  endtask

  // Pulse go, optionally re-pulse it at loop cycle regot, and wait (bounded) for done.
  task automatic run_sweep(input int regot, input int budget,
                           output logic [N-1:0] st1, output logic [N-1:0] st2);
    bit seen;
    seen = 1'b0;
    st1  = '0;
    st2  = '0;
    @(negedge clk) go = 1'b1;
    for (int cyc = 0; cyc < budget && !seen; cyc++) begin
      @(negedge clk);
      go = (cyc == regot);
      if (cyc == 0) st1 = start;
      if (cyc == 1) st2 = start;
      if (done) seen = 1'b1;
    end
    go = 1'b0;
    check_eq("sweep_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic check_order(input string tag, input int base);
    check_eq({tag, "_runs"}, 32'(rise_idx.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < rise_idx.size()) begin
        check_eq({tag, "_idx"}, 32'(rise_idx[base + k]), 32'(k));
        check_eq({tag, "_width"}, 32'(widths[base + k]), 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [N-1:0] st1, st2;
    logic [3:0]   w;
    int           base, dbase;
    bit           found;

    rst = 1'b1; go = 1'b0; go2 = 1'b0; stp_force = '0; stub_clr = 1'b1;
    stopped2 = '0; colour2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_start",   32'(start),   32'd0);
    check_eq("rst_busy",    32'(busy),    32'd0);
    check_eq("rst_done",    32'(done),    32'd0);
    check_eq("rst_cur_idx", 32'(cur_idx), 32'd0);
    check_eq("rst_result",  32'(result),  32'd0);
    check_eq("rst_valid",   32'(valid),   32'd0);
    rst = 1'b0;
    @(negedge clk) stub_clr = 1'b0;

    // Basic sweep
    base = rise_idx.size(); dbase = done_cnt;
    run_sweep(-1, 2000, st1, st2);
    check_eq("go_latency_c1", 32'(st1), 32'd0);
    check_eq("go_latency_c2", 32'(st2), 32'b0001);
    repeat (3) @(negedge clk);
    check_eq("sweep1_result", 32'(result), 32'b0110);
    check_eq("sweep1_valid",  32'(valid),  32'b1111);
    check_eq("sweep1_busy",   32'(busy),   32'd0);
    check_eq("sweep1_dones",  32'(done_cnt - dbase), 32'd1);
    check_order("sweep1", base);

    // Second go while busy is dropped
    clr_stubs();
    base = rise_idx.size(); dbase = done_cnt;
    run_sweep(30, 2000, st1, st2);
    repeat (30) @(negedge clk);
    check_eq("regot_dones", 32'(done_cnt - dbase), 32'd1);
    check_eq("regot_busy",  32'(busy), 32'd0);
    check_order("regot", base);

    // Stale stopped on instance 2 holds the FSM in ARM
    clr_stubs();
    stp_force[2] = 1'b1;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (cur_idx == 4'd2 && busy) found = 1'b1;
    end
    check_eq("arm_reach_idx2", 32'(found), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("arm_hold_start", 32'(start),   32'd0);
    check_eq("arm_hold_idx",   32'(cur_idx), 32'd2);
    stp_force[2] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (start == 4'b0100) found = 1'b1;
    end
    check_eq("arm_release_pulse", 32'(found), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check_eq("arm_sweep_done", 32'(found), 32'd1);
    check_eq("arm_result", 32'(result), 32'b0110);

    // Reset in the middle of instance 1's WAIT
    clr_stubs();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (start == 4'b0010) found = 1'b1;
    end
    check_eq("midrst_saw_start1", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    check_eq("midrst_pre_valid", 32'(valid), 32'b0001);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_start",  32'(start),  32'd0);
    check_eq("midrst_busy",   32'(busy),   32'd0);
    check_eq("midrst_valid",  32'(valid),  32'd0);
    check_eq("midrst_result", 32'(result), 32'd0);
    @(negedge clk) stub_clr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stub_clr = 1'b0;
    base = rise_idx.size();
    run_sweep(-1, 2000, st1, st2);
    check_eq("midrst_rerun_first", 32'(st2), 32'b0001);
    check_eq("midrst_rerun_result", 32'(result), 32'b0110);
    check_order("midrst", base);

`ifdef RUN_TIMEOUT_EN
    // Instance 1 never stops; the watchdog completes the run
    dly[1] = 0;
    clr_stubs();
    run_sweep(-1, 3000, st1, st2);
    check_eq("tmo_flags",  32'(timed_out), 32'b0010);
    check_eq("tmo_result", 32'(result),    32'b0100);
    check_eq("tmo_valid",  32'(valid),     32'b1111);
    dly[1] = 35;
`endif

    // START_CYC=3, GAP_CYC=0 instance driven by hand
    @(negedge clk) go2 = 1'b1;
    @(negedge clk) go2 = 1'b0;
    check_eq("u2_c1_start", 32'(start2), 32'd0);
    check_eq("u2_c1_busy",  32'(busy2),  32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      w[3 - c] = start2[0];
    end
    check_eq("u2_pulse_width", 32'(w), 32'b1110);
    stopped2[0] = 1'b1; colour2[0] = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("u2_capt_valid", 32'(valid2),   32'b01);
    check_eq("u2_capt_idx",   32'(cur_idx2), 32'd1);
    check_eq("u2_arm_start",  32'(start2),   32'd0);
    @(negedge clk);
    check_eq("u2_nogap_start", 32'(start2), 32'b10);
    stopped2[1] = 1'b1; colour2[1] = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (done2) found = 1'b1;
    end
    check_eq("u2_done",   32'(found),   32'd1);
    check_eq("u2_result", 32'(result2), 32'b01);
    check_eq("u2_valid",  32'(valid2),  32'b11);

    check_eq("onehot_start", 32'(multi_hot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
